// File: rtl/fc_tx_framer_if.sv
// Frame-word input and transceiver TX stream between the frame source,
// the framer and the FC 8G transceiver.
interface fc_tx_framer_if;
   logic [31:0] fr_data;
   logic        fr_valid;
   logic        fr_ready;
   logic        fr_sop;
   logic        fr_eop;
   logic [1:0]  fr_sof_sel;
   logic        fr_eof_t;
   logic [35:0] avtx_data;
   logic        avtx_valid;
   logic        avtx_ready;

   modport master (
      output fr_data, fr_valid, fr_sop, fr_eop, fr_sof_sel, fr_eof_t, avtx_ready,
      input  fr_ready, avtx_data, avtx_valid
   );

   modport slave (
      input  fr_data, fr_valid, fr_sop, fr_eop, fr_sof_sel, fr_eof_t, avtx_ready,
      output fr_ready, avtx_data, avtx_valid
   );
endinterface

// File: rtl/fc_tx_framer.sv
// FC 8G TX framer: wraps upstream frames in SOF/EOF, enforces the inter-frame
// IDLE gap, and substitutes primitive sequences on request from the port FSM.
module fc_tx_framer #(
   parameter int unsigned MIN_IDLES = 6,
   parameter int unsigned MAX_WORDS = 537
) (
   input  logic               tx_clk,
   input  logic               reset_n,
   fc_tx_framer_if.slave      bus,
   input  logic [2:0]         prim_seq_sel,
   output logic [31:0]        frames_sent,
   output logic [15:0]        frames_aborted
);
   localparam int unsigned GAP_W = $clog2(MIN_IDLES + 1);
   localparam int unsigned WC_W  = $clog2(MAX_WORDS + 1);

   localparam logic [3:0]  OS_K   = 4'b1000;
   localparam logic [31:0] IDLE_W = 32'hBC95_B5B5;
   localparam logic [31:0] EOFT_W = 32'hBC95_7575;
   localparam logic [31:0] EOFN_W = 32'hBC95_D5D5;
   localparam logic [31:0] EOFA_W = 32'hBC95_F5F5;

   typedef enum logic [2:0] {
      ST_GAP,
      ST_DATA,
      ST_EOF,
      ST_DROP,
      ST_PSEQ
   } state_e;

   state_e             state_q, state_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
   logic               eof_t_q, eof_t_d;
   logic               flush_q, flush_d;
   logic [35:0]        data_q, data_d;
   logic               valid_q, valid_d;
   logic [31:0]        sent_q, sent_d;
   logic [15:0]        aborted_q, aborted_d;
   logic               fr_ready_c;
   logic               advance_c;
   logic               eop_c;
   logic               gap_full_c;
   logic [GAP_W-1:0]   gap_inc_c;

   function automatic logic [31:0] prim_word(input logic [2:0] sel);
      case (sel)
         3'd2:    prim_word = 32'hBC35_8A55;
         3'd3:    prim_word = 32'hBC49_BF49;
         3'd4:    prim_word = 32'hBC35_BF49;
         default: prim_word = 32'hBC55_BF45;
      endcase
   endfunction

   function automatic logic [31:0] sof_word(input logic [1:0] sel);
      case (sel)
         2'd0:    sof_word = 32'hBCB5_5656;
         2'd2:    sof_word = 32'hBCB5_5858;
         default: sof_word = 32'hBCB5_3636;
      endcase
   endfunction

   assign advance_c  = bus.avtx_ready || !valid_q;
   assign eop_c      = bus.fr_valid && bus.fr_eop;
   assign gap_full_c = gap_cnt_q >= GAP_W'(MIN_IDLES);
   assign gap_inc_c  = gap_full_c ? gap_cnt_q : gap_cnt_q + GAP_W'(1);

   always_ff @(posedge tx_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_GAP;
         gap_cnt_q  <= '0;
         word_cnt_q <= '0;
         eof_t_q    <= 1'b0;
         flush_q    <= 1'b0;
         data_q     <= {OS_K, IDLE_W};
         valid_q    <= 1'b0;
         sent_q     <= '0;
         aborted_q  <= '0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         word_cnt_q <= word_cnt_d;
         eof_t_q    <= eof_t_d;
         flush_q    <= flush_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         sent_q     <= sent_d;
         aborted_q  <= aborted_d;
      end
   end

   // SOF and EOFa are loaded on the transition advance itself, so they need no state of their own.
   always_comb begin
      state_d    = state_q;
      gap_cnt_d  = gap_cnt_q;
      word_cnt_d = word_cnt_q;
      eof_t_d    = eof_t_q;
      flush_d    = flush_q;
      data_d     = data_q;
      valid_d    = valid_q;
      sent_d     = sent_q;
      aborted_d  = aborted_q;
      fr_ready_c = 1'b0;

      if (advance_c) valid_d = 1'b1;

      case (state_q)
         ST_GAP: begin
            fr_ready_c = valid_q && !bus.fr_sop;
            if (advance_c) begin
               if (prim_seq_sel != 3'd0) begin
                  data_d  = {OS_K, prim_word(prim_seq_sel)};
                  flush_d = 1'b0;
                  state_d = ST_PSEQ;
               end else if (gap_full_c && bus.fr_valid && bus.fr_sop) begin
                  data_d     = {OS_K, sof_word(bus.fr_sof_sel)};
                  word_cnt_d = '0;
                  state_d    = ST_DATA;
               end else begin
                  data_d    = {OS_K, IDLE_W};
                  gap_cnt_d = gap_inc_c;
               end
            end
         end
         ST_DATA: begin
            fr_ready_c = advance_c;
            if (advance_c) begin
               // Max-length check applies even to the eop word: that word is swallowed with the abort.
               if (eop_c && word_cnt_q != WC_W'(MAX_WORDS)) begin
                  data_d     = {4'b0000, bus.fr_data};
                  word_cnt_d = word_cnt_q + WC_W'(1);
                  eof_t_d    = bus.fr_eof_t;
                  state_d    = ST_EOF;
               end else if (prim_seq_sel != 3'd0 || !bus.fr_valid ||
                            word_cnt_q == WC_W'(MAX_WORDS)) begin
                  data_d    = {OS_K, EOFA_W};
                  aborted_d = aborted_q + 16'd1;
                  gap_cnt_d = '0;
                  flush_d   = !eop_c;
                  if (prim_seq_sel != 3'd0) state_d = ST_PSEQ;
                  else if (eop_c)           state_d = ST_GAP;
                  else                      state_d = ST_DROP;
               end else begin
                  data_d     = {4'b0000, bus.fr_data};
                  word_cnt_d = word_cnt_q + WC_W'(1);
               end
            end
         end
         ST_EOF: begin
            if (advance_c) begin
               data_d    = {OS_K, eof_t_q ? EOFT_W : EOFN_W};
               sent_d    = sent_q + 32'd1;
               gap_cnt_d = '0;
               state_d   = ST_GAP;
            end
         end
         ST_DROP: begin
            fr_ready_c = 1'b1;
            if (advance_c && prim_seq_sel != 3'd0) begin
               data_d  = {OS_K, prim_word(prim_seq_sel)};
               flush_d = !eop_c;
               state_d = ST_PSEQ;
            end else begin
               if (advance_c) begin
                  data_d    = {OS_K, IDLE_W};
                  gap_cnt_d = gap_inc_c;
               end
               if (eop_c) state_d = ST_GAP;
            end
         end
         ST_PSEQ: begin
            if (advance_c) begin
               if (prim_seq_sel != 3'd0) begin
                  data_d = {OS_K, prim_word(prim_seq_sel)};
               end else begin
                  // This advance already acts as the first gap IDLE.
                  data_d    = {OS_K, IDLE_W};
                  gap_cnt_d = GAP_W'(1);
                  state_d   = flush_q ? ST_DROP : ST_GAP;
               end
            end
         end
         default: state_d = ST_GAP;
      endcase
   end

   assign bus.fr_ready   = fr_ready_c;
   assign bus.avtx_data  = data_q;
   assign bus.avtx_valid = valid_q;
   assign frames_sent    = sent_q;
   assign frames_aborted = aborted_q;
endmodule
